// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered MIPS decode/control stage between IF/ID and EX
// Ports: CLK/nRST clock and async active-low reset; instr/instr_valid from the IF/ID latch;
// ex_ready back-pressure from EX; flush squashes the instruction in decode; id_stall tells IF
// to hold instr; ex_* registered control word for EX; halt_seen/illegal sticky status;
// bubble_cnt saturating count of inserted bubbles.
module decode_ctrl_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned CNT_W     = 16,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_regwrite,
    output logic              ex_dren,
    output logic              ex_dwen,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_halt,
    output logic [1:0]        ex_branch,
    output logic [1:0]        ex_jump,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wsel,
    output logic [DATA_W-1:0] ex_imm,
    output logic              halt_seen,
    output logic              illegal,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                           ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                           F_SLTU = 6'h2B;

    typedef struct packed {
        logic              valid;
        logic [3:0]        aluop;
        logic              regwrite, dren, dwen, memtoreg, alusrc, halt;
        logic [1:0]        branch, jump;
        logic [REG_AW-1:0] rs, rt, wsel;
        logic [DATA_W-1:0] imm;
    } ctrl_t;

    ctrl_t             ctrl_q, ctrl_d, dec;
    logic              halt_q, halt_d, ill_q, ill_d, bad, uses_rt, hazard, cnt_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        op, fn;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] sext, zext;

    assign op   = instr[31:26];
    assign fn   = instr[5:0];
    assign rs   = REG_AW'(instr[25:21]);
    assign rt   = REG_AW'(instr[20:16]);
    assign rd   = REG_AW'(instr[15:11]);
    assign sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign zext = DATA_W'(instr[15:0]);

    always_comb begin
        dec       = '0;
        bad       = 1'b0;
        dec.valid = 1'b1;
        dec.aluop = ALU_ADD;
        dec.rs    = rs;
        dec.rt    = rt;
        dec.wsel  = rt;
        dec.imm   = sext;
        case (op)
            OP_R: begin
                dec.wsel     = rd;
                dec.regwrite = 1'b1;
                case (fn)
                    F_SLL:         begin dec.aluop = ALU_SLL; dec.imm = DATA_W'(instr[10:6]); end
                    F_SRL:         begin dec.aluop = ALU_SRL; dec.imm = DATA_W'(instr[10:6]); end
                    F_JR:          begin dec.regwrite = 1'b0; dec.jump = 2'b01; end
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_XOR:         dec.aluop = ALU_XOR;
                    F_NOR:         dec.aluop = ALU_NOR;
                    F_SLT:         dec.aluop = ALU_SLT;
                    F_SLTU:        dec.aluop = ALU_SLTU;
                    default:       bad = 1'b1;
                endcase
            end
            OP_J:              dec.jump = 2'b10;
            OP_JAL:            begin dec.jump = 2'b11; dec.regwrite = 1'b1; dec.wsel = REG_AW'(31); end
            OP_BEQ:            begin dec.branch = 2'b01; dec.aluop = ALU_SUB; end
            OP_BNE:            begin dec.branch = 2'b10; dec.aluop = ALU_SUB; end
            OP_ADDI, OP_ADDIU: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
            OP_SLTI:           begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_SLT; end
            OP_SLTIU:          begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_SLTU; end
            OP_ANDI:           begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_AND; dec.imm = zext; end
            OP_ORI:            begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_OR; dec.imm = zext; end
            OP_XORI:           begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_XOR; dec.imm = zext; end
            OP_LUI:            begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = DATA_W'({instr[15:0], 16'h0000}); end
            OP_LW:             begin dec.regwrite = 1'b1; dec.dren = 1'b1; dec.memtoreg = 1'b1; dec.alusrc = 1'b1; end
            OP_SW:             begin dec.dwen = 1'b1; dec.alusrc = 1'b1; end
            OP_HALT:           dec.halt = 1'b1;
            default:           bad = 1'b1;
        endcase
    end

    // Only a load sitting in EX can create a load-use hazard; $0 never does.
    assign uses_rt  = (op == OP_R) | (op == OP_BEQ) | (op == OP_BNE) | (op == OP_SW);
    assign hazard   = HAZARD_EN & ctrl_q.valid & ctrl_q.dren & (ctrl_q.wsel != '0) &
                      ((ctrl_q.wsel == rs) | (uses_rt & (ctrl_q.wsel == rt)));
    assign id_stall = ~flush & (halt_q | ~ex_ready | (instr_valid & hazard));

    always_comb begin
        ctrl_d  = '0;
        cnt_inc = 1'b0;
        halt_d  = halt_q;
        ill_d   = ill_q;
        if (flush) cnt_inc = 1'b1;
        else if (halt_q) ctrl_d = '0;
        else if (!ex_ready) ctrl_d = ctrl_q;
        else if (instr_valid & hazard) cnt_inc = 1'b1;
        else if (instr_valid) begin
            ctrl_d = bad ? '0 : dec;
            ill_d  = ill_q | bad;
            halt_d = dec.halt & ~bad;
        end
        cnt_d = (cnt_inc & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctrl_q <= '0;
            halt_q <= 1'b0;
            ill_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            halt_q <= halt_d;
            ill_q  <= ill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid    = ctrl_q.valid;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_dren     = ctrl_q.dren;
    assign ex_dwen     = ctrl_q.dwen;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_halt     = ctrl_q.halt;
    assign ex_branch   = ctrl_q.branch;
    assign ex_jump     = ctrl_q.jump;
    assign ex_rs       = ctrl_q.rs;
    assign ex_rt       = ctrl_q.rt;
    assign ex_wsel     = ctrl_q.wsel;
    assign ex_imm      = ctrl_q.imm;
    assign halt_seen   = halt_q;
    assign illegal     = ill_q;
    assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed vector bench for decode_ctrl_stage
module tb_decode_ctrl_stage;
    logic        CLK = 1'b0, nRST = 1'b0, iv = 1'b0, rdy = 1'b1, fl = 1'b0;
    logic [31:0] instr = '0;
    int          n_cmp = 0, n_bad = 0;

    always #5 CLK = ~CLK;

    localparam logic [5:0] RW = 6'b100000, DR = 6'b010000, DW = 6'b001000,
                           MR = 6'b000100, AS = 6'b000010, HT = 6'b000001;

    typedef struct {
        logic [31:0] instr;
        logic        iv, rdy, fl, stall, nstall;
        logic [61:0] word;
        logic        il, hs;
        logic [15:0] cnt;
    } vec_t;
    vec_t vt[$];

    logic a_stall, a_valid, a_rw, a_dr, a_dw, a_mr, a_as, a_ht, a_hs, a_il;
    logic [3:0] a_aluop; logic [1:0] a_br, a_jp; logic [4:0] a_rs, a_rt, a_ws;
    logic [31:0] a_imm; logic [15:0] a_cnt;
    logic n_stall, n_valid, n_rw, n_dr, n_dw, n_mr, n_as, n_ht, n_hs, n_il;
    logic [3:0] n_aluop; logic [1:0] n_br, n_jp; logic [4:0] n_rs, n_rt, n_ws;
    logic [31:0] n_imm; logic [15:0] n_cnt;
    logic c_stall, c_valid, c_rw, c_dr, c_dw, c_mr, c_as, c_ht, c_hs, c_il;
    logic [3:0] c_aluop; logic [1:0] c_br, c_jp; logic [4:0] c_rs, c_rt, c_ws;
    logic [31:0] c_imm; logic [3:0] c_cnt;
    logic [61:0] a_word;

    assign a_word = {a_valid, a_aluop, a_rw, a_dr, a_dw, a_mr, a_as, a_ht, a_br, a_jp, a_rs, a_rt, a_ws, a_imm};

    decode_ctrl_stage u_a (
        .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(iv), .ex_ready(rdy), .flush(fl),
        .id_stall(a_stall), .ex_valid(a_valid), .ex_aluop(a_aluop), .ex_regwrite(a_rw),
        .ex_dren(a_dr), .ex_dwen(a_dw), .ex_memtoreg(a_mr), .ex_alusrc(a_as), .ex_halt(a_ht),
        .ex_branch(a_br), .ex_jump(a_jp), .ex_rs(a_rs), .ex_rt(a_rt), .ex_wsel(a_ws),
        .ex_imm(a_imm), .halt_seen(a_hs), .illegal(a_il), .bubble_cnt(a_cnt)
    );

    decode_ctrl_stage #(.HAZARD_EN(1'b0)) u_n (
        .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(iv), .ex_ready(rdy), .flush(fl),
        .id_stall(n_stall), .ex_valid(n_valid), .ex_aluop(n_aluop), .ex_regwrite(n_rw),
        .ex_dren(n_dr), .ex_dwen(n_dw), .ex_memtoreg(n_mr), .ex_alusrc(n_as), .ex_halt(n_ht),
        .ex_branch(n_br), .ex_jump(n_jp), .ex_rs(n_rs), .ex_rt(n_rt), .ex_wsel(n_ws),
        .ex_imm(n_imm), .halt_seen(n_hs), .illegal(n_il), .bubble_cnt(n_cnt)
    );

    decode_ctrl_stage #(.CNT_W(4)) u_c (
        .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(iv), .ex_ready(rdy), .flush(fl),
        .id_stall(c_stall), .ex_valid(c_valid), .ex_aluop(c_aluop), .ex_regwrite(c_rw),
        .ex_dren(c_dr), .ex_dwen(c_dw), .ex_memtoreg(c_mr), .ex_alusrc(c_as), .ex_halt(c_ht),
        .ex_branch(c_br), .ex_jump(c_jp), .ex_rs(c_rs), .ex_rt(c_rt), .ex_wsel(c_ws),
        .ex_imm(c_imm), .halt_seen(c_hs), .illegal(c_il), .bubble_cnt(c_cnt)
    );

    function automatic logic [61:0] w(input logic v, input logic [3:0] a, input logic [5:0] f,
                                      input logic [1:0] b, input logic [1:0] j, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] ws, input logic [31:0] im);
        return {v, a, f, b, j, rs, rt, ws, im};
    endfunction

    task automatic add(input logic [31:0] i, input logic v_, input logic r_, input logic f_,
                       input logic s_, input logic ns_, input logic [61:0] wd,
                       input logic il_, input logic hs_, input int c);
        vt.push_back('{i, v_, r_, f_, s_, ns_, wd, il_, hs_, 16'(c)});
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    logic [61:0] wlw, wadd2, wb;

    initial begin
        wb    = '0;
        wlw   = w(1, 4'd2, RW | DR | MR | AS, 2'b00, 2'b00, 5'd1, 5'd4, 5'd4, 32'h0);
        wadd2 = w(1, 4'd2, RW, 2'b00, 2'b00, 5'd4, 5'd1, 5'd5, 32'h2820);
        // instr, valid, ready, flush, stall, no-hazard-dut stall, word, illegal, halt_seen, count
        add(32'h00221820, 1, 1, 0, 0, 0, w(1, 4'd2, RW, 2'b00, 2'b00, 5'd1, 5'd2, 5'd3, 32'h1820), 0, 0, 0);
        add(32'h3C011234, 1, 1, 0, 0, 0, w(1, 4'd2, RW | AS, 2'b00, 2'b00, 5'd0, 5'd1, 5'd1, 32'h12340000), 0, 0, 0);
        add(32'h0C000010, 1, 1, 0, 0, 0, w(1, 4'd2, RW, 2'b00, 2'b11, 5'd0, 5'd0, 5'd31, 32'h10), 0, 0, 0);
        add(32'h3402FFFF, 1, 1, 0, 0, 0, w(1, 4'd5, RW | AS, 2'b00, 2'b00, 5'd0, 5'd2, 5'd2, 32'h0000FFFF), 0, 0, 0);
        add(32'h2002FFFF, 1, 1, 0, 0, 0, w(1, 4'd2, RW | AS, 2'b00, 2'b00, 5'd0, 5'd2, 5'd2, 32'hFFFFFFFF), 0, 0, 0);
        add(32'h00021900, 1, 1, 0, 0, 0, w(1, 4'd0, RW, 2'b00, 2'b00, 5'd0, 5'd2, 5'd3, 32'h4), 0, 0, 0);
        add(32'h10220004, 1, 1, 0, 0, 0, w(1, 4'd3, 6'b0, 2'b01, 2'b00, 5'd1, 5'd2, 5'd2, 32'h4), 0, 0, 0);
        add(32'hAC220008, 1, 1, 0, 0, 0, w(1, 4'd2, DW | AS, 2'b00, 2'b00, 5'd1, 5'd2, 5'd2, 32'h8), 0, 0, 0);
        add(32'h03E00008, 1, 1, 0, 0, 0, w(1, 4'd2, 6'b0, 2'b00, 2'b01, 5'd31, 5'd0, 5'd0, 32'h8), 0, 0, 0);
        add(32'h8C240000, 1, 1, 0, 0, 0, wlw, 0, 0, 0);
        add(32'h00812820, 1, 1, 0, 1, 0, wb, 0, 0, 1);
        add(32'h00812820, 1, 1, 0, 0, 0, wadd2, 0, 0, 1);
        add(32'h20060007, 1, 0, 0, 1, 1, wadd2, 0, 0, 1);
        add(32'h20060007, 1, 0, 0, 1, 1, wadd2, 0, 0, 1);
        add(32'h20060007, 1, 0, 0, 1, 1, wadd2, 0, 0, 1);
        add(32'h20060007, 1, 1, 0, 0, 0, w(1, 4'd2, RW | AS, 2'b00, 2'b00, 5'd0, 5'd6, 5'd6, 32'h7), 0, 0, 1);
        add(32'h8C240000, 1, 1, 0, 0, 0, wlw, 0, 0, 1);
        add(32'h00812820, 1, 1, 1, 0, 0, wb, 0, 0, 2);
        add(32'h00812820, 1, 1, 0, 0, 0, wadd2, 0, 0, 2);
        add(32'h00000000, 0, 1, 0, 0, 0, wb, 0, 0, 2);
        add(32'h70000000, 1, 1, 0, 0, 0, wb, 1, 0, 2);
        add(32'h0000003F, 1, 1, 0, 0, 0, wb, 1, 0, 2);
        add(32'hFC000000, 1, 1, 0, 0, 0, w(1, 4'd2, HT, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0), 1, 1, 2);
        add(32'h00221820, 1, 0, 0, 1, 1, wb, 1, 1, 2);
        add(32'h00000000, 0, 1, 0, 1, 1, wb, 1, 1, 2);
        add(32'h00221820, 1, 1, 1, 0, 0, wb, 1, 1, 3);

        #12;
        chk("reset_word", 0, 64'(a_word), 64'd0);
        chk("reset_status", 0, 64'({a_il, a_hs, a_cnt}), 64'd0);
        chk("reset_stall", 0, 64'(a_stall), 64'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < vt.size(); i++) begin
            instr = vt[i].instr; iv = vt[i].iv; rdy = vt[i].rdy; fl = vt[i].fl;
            @(negedge CLK);
            chk("stall", i, 64'(a_stall), 64'(vt[i].stall));
            chk("nohaz_stall", i, 64'(n_stall), 64'(vt[i].nstall));
            @(posedge CLK); #1;
            chk("word", i, 64'(a_word), 64'(vt[i].word));
            chk("status", i, 64'({a_il, a_hs, a_cnt}), 64'({vt[i].il, vt[i].hs, vt[i].cnt}));
            chk("cnt4", i, 64'(c_cnt), 64'(vt[i].cnt[3:0]));
        end

        nRST = 1'b0; #1 nRST = 1'b1;
        instr = '0; iv = 1'b0; rdy = 1'b1; fl = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        chk("sat_cnt16", 0, 64'(a_cnt), 64'd20);
        chk("sat_cnt4", 0, 64'(c_cnt), 64'd15);
        fl = 1'b0; iv = 1'b1; instr = 32'h8C240000;
        @(posedge CLK); #1;
        chk("lw_issue", 0, 64'(a_word), 64'(wlw));
        instr = 32'h00812820;
        @(negedge CLK);
        chk("mid_stall", 0, 64'(a_stall), 64'd1);
        #1 nRST = 1'b0;
        #1;
        chk("async_rst_word", 0, 64'(a_word), 64'd0);
        chk("async_rst_status", 0, 64'({a_il, a_hs, a_cnt}), 64'd0);
        chk("async_rst_stall", 0, 64'(a_stall), 64'd0);
        chk("async_rst_cnt4", 0, 64'(c_cnt), 64'd0);
        @(posedge CLK); #1;
        chk("rst_hold_word", 0, 64'(a_word), 64'd0);
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_stall", 0, 64'(a_stall), 64'd0);
        @(posedge CLK); #1;
        chk("post_rst_issue", 0, 64'(a_word), 64'(wadd2));
        chk("post_rst_cnt", 0, 64'(a_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered, hazard-aware successor to the combinational MIPS control decoder; sits between IF/ID and the EX stage of the pipelined datapath.
- Each cycle it decodes one instruction into the full control word (including resolved write-select and extended immediate) and registers it for EX.
- It also handles load-use bubble insertion, downstream back-pressure, flush, sticky halt/illegal status and a saturating bubble counter.

Parameters:
- DATA_W, 32, datapath/instruction width (opcode and funct positions fixed per MIPS, bits [31:26] and [5:0]).
- REG_AW, 5, register address width; register 31 is link register.
- CNT_W, 16, bubble counter width.
- HAZARD_EN, 1, 1 enables load-use detection; 0 disables it (id_stall then depends only on ex_ready and halt).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- instr  in  DATA_W  instruction from IF/ID latch.
- instr_valid  in  1  instr is a real instruction.
- ex_ready  in  1  EX can accept a new control word this cycle.
- flush  in  1  squash the instruction being decoded (branch/jump resolved taken).
- id_stall  out  1  combinational; IF must hold instr when 1.
- ex_valid  out  1  registered control word valid.
- ex_aluop  out  4  aluop_t code.
- ex_regwrite, ex_dren, ex_dwen, ex_memtoreg, ex_alusrc, ex_halt  out  1 each  control bits.
- ex_branch  out  2  01 BEQ, 10 BNE.
- ex_jump  out  2  01 JR, 10 J, 11 JAL.
- ex_rs, ex_rt  out  REG_AW  source register indices.
- ex_wsel  out  REG_AW  destination: rd (R-type), rt (I-type), 31 (JAL).
- ex_imm  out  DATA_W  imm16 sign/zero extended; LUI gives imm16<<16; shift ops give zero-extended shamt.
- halt_seen  out  1  sticky, HALT issued to EX.
- illegal  out  1  sticky, unknown opcode/funct decoded.
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (async, nRST=0): all ex_* outputs 0, ex_valid=0, halt_seen=0, illegal=0, bubble_cnt=0. id_stall is combinational from the reset-zero state, so it is 0 unless ex_ready=0.
- Decode uses the same opcode/funct to aluop and control mapping as the existing single-cycle unit. ExtOp is sign-extend for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE and zero-extend for ANDI, ORI, XORI.
- Unknown opcode or R-type funct:
  - The control word is forced to a bubble.
  - illegal is set on the edge where that instruction would have advanced.
- uses_rt = 1 for R-type, BEQ, BNE, SW.
- hazard = HAZARD_EN & ex_valid & ex_dren & (ex_wsel≠0) & (ex_wsel==rs | (uses_rt & ex_wsel==rt)).
- id_stall = ~flush & (halt_seen | ~ex_ready | (instr_valid & hazard)).
- Per-edge priority (highest first):
  1. flush: load a bubble (ex_valid=0, all controls 0); count a bubble.
  2. halt_seen: load a bubble; not counted.
  3. ~ex_ready: hold all ex_* registers unchanged.
  4. instr_valid & hazard: load a bubble; count it. instr is held by IF and advances on the next edge.
  5. instr_valid: load the decoded word with ex_valid=1. If it is HALT, set halt_seen on the same edge.
  6. otherwise: load a bubble; not counted.
- "Bubble": ex_valid=0 and every control bit 0, so a stale control word never reaches EX.
- bubble_cnt saturates at 2^CNT_W−1; no wrap.
- Latency: a decoded word appears on ex_* exactly one edge after acceptance. A load-use pair costs exactly one bubble.
- Reset mid-stall or mid-hazard clears everything immediately; no pending state survives.
- flush and a hazard in the same cycle: flush wins, id_stall=0, and one bubble is counted.

Test Plan:
- Decode sweep: ADD $3,$1,$2 (0x00221820) -> next edge ex_valid=1, ex_aluop=ALU_ADD, ex_regwrite=1, ex_wsel=3. LUI $1,0x1234 (0x3C011234) -> ex_imm=0x12340000, ex_wsel=1. JAL (0x0C000010) -> ex_jump=11, ex_wsel=31.
- Load-use: LW $4,0($1) (0x8C240000) then ADD $5,$4,$1 (0x00812820) -> id_stall=1 for one cycle, one bubble, ADD appears on the second edge, bubble_cnt=1. Repeat with HAZARD_EN=0 -> no stall.
- Back-pressure: ex_ready=0 for 3 cycles with ADDI valid -> ex_* unchanged, id_stall=1, bubble_cnt unchanged; the ADDI issues on the first ex_ready=1 edge.
- Flush with concurrent hazard: flush=1 while the LW/ADD hazard is active -> id_stall=0, ex_valid=0 next edge, bubble_cnt +1.
- Halt/illegal: 0xFC000000 -> ex_halt=1, halt_seen=1, then all later instructions become bubbles with id_stall=1. 0x70000000 -> ex_valid=0, illegal=1 sticky.
- Async reset asserted mid-stall, plus bubble_cnt preloaded near saturation with CNT_W=4 -> reset clears all outputs without a clock edge; the counter holds at 15.
